// File: rtl/seq_magcmp_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
package seq_magcmp_pkg;

  // Controller states: waiting for a request, or walking the chunks MSB first.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Result encoding, ordered as {gt, eq, lt}.
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;

  // Width of the chunk index counter; never less than one bit so that a
  // single-chunk configuration still has a legal counter.
  function automatic int idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/magcmp_chunk.sv
// Combinational CHUNK-bit unsigned comparator built as a cascade of 1-bit
// magnitude cells: the most significant differing bit decides the result.
module magcmp_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  // gt_acc[i]/lt_acc[i] hold the verdict of bits [i-1:0]; higher bits override.
  logic [CHUNK:0] gt_acc;
  logic [CHUNK:0] lt_acc;

  assign gt_acc[0] = 1'b0;
  assign lt_acc[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
      // A differing bit decides on its own; an equal bit defers to the lower bits.
      assign gt_acc[gi+1] = (x[gi] & ~y[gi]) | (~(x[gi] ^ y[gi]) & gt_acc[gi]);
      assign lt_acc[gi+1] = (~x[gi] & y[gi]) | (~(x[gi] ^ y[gi]) & lt_acc[gi]);
    end
  endgenerate

  assign gt = gt_acc[CHUNK];
  assign lt = lt_acc[CHUNK];
  assign eq = ~(gt_acc[CHUNK] | lt_acc[CHUNK]);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Sequential magnitude comparator: compares two WIDTH-bit operands CHUNK bits
// per cycle, MSB chunk first, stopping at the first differing chunk. Signed
// compares are handled by flipping both MSBs at capture, after which the
// datapath is purely unsigned. WIDTH must be a multiple of CHUNK.
module seq_magnitude_comparator
  import seq_magcmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = idx_width(NCHUNK);

  state_t           state_reg, state_next;
  logic [IW-1:0]    idx_reg, idx_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [2:0]       res_reg, res_next;

  logic [WIDTH-1:0] msb_flip;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic             c_gt, c_eq, c_lt;

  // Current chunk is picked straight out of the held operands by idx.
  assign a_chunk = a_reg[idx_reg*CHUNK +: CHUNK];
  assign b_chunk = b_reg[idx_reg*CHUNK +: CHUNK];

  magcmp_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .x  (a_chunk),
    .y  (b_chunk),
    .gt (c_gt),
    .eq (c_eq),
    .lt (c_lt)
  );

  // Next-state logic: capture on start in IDLE, decide or step down in RUN.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    res_next   = res_reg;
    msb_flip   = '0;
    msb_flip[WIDTH-1] = signed_mode;
    case (state_reg)
      IDLE: begin
        if (start) begin
          // Flipping the sign bit maps two's complement order onto unsigned order.
          a_next     = a ^ msb_flip;
          b_next     = b ^ msb_flip;
          idx_next   = IW'(NCHUNK - 1);
          busy_next  = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (!c_eq) begin
          res_next   = c_gt ? RES_GT : RES_LT;
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else if (idx_reg == '0) begin
          res_next   = RES_EQ;
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          idx_next = idx_reg - IW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State, operand, and output registers; reset aborts any compare in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      res_reg   <= RES_NONE;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      res_reg   <= res_next;
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign gt   = res_reg[2];
  assign eq   = res_reg[1];
  assign lt   = res_reg[0];

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Scoreboard bench: the driver pushes expected {gt,eq,lt} and completion cycle
// on each accepted start; monitors pop and compare whenever done pulses.
module tb_seq_magnitude_comparator;

  localparam logic [2:0] R_GT = 3'b100;
  localparam logic [2:0] R_EQ = 3'b010;
  localparam logic [2:0] R_LT = 3'b001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // 16-bit / 4-bit-chunk instance
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        signed_mode = 1'b0;
  logic        busy, done, gt, eq, lt;

  // 1-bit / 1-bit-chunk instance
  logic        start1 = 1'b0;
  logic [0:0]  a1 = '0;
  logic [0:0]  b1 = '0;
  logic        s1 = 1'b0;
  logic        busy1, done1, gt1, eq1, lt1;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0] last_exp = 3'b000;

  logic [2:0] q_res[$];
  int         q_due[$];
  int         q_tag[$];
  logic [2:0] q1_res[$];
  int         q1_due[$];
  int         q1_tag[$];

  seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .signed_mode(signed_mode),
    .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt)
  );

  seq_magnitude_comparator #(.WIDTH(1), .CHUNK(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .signed_mode(s1),
    .busy(busy1), .done(done1), .gt(gt1), .eq(eq1), .lt(lt1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the wide instance.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q_res.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [2:0] r;
        int d, t;
        r = q_res.pop_front();
        d = q_due.pop_front();
        t = q_tag.pop_front();
        $display("txn %0d: gt=%0b eq=%0b lt=%0b at cycle %0d", t, gt, eq, lt, cyc);
        check($sformatf("result_%0d", t), {29'd0, gt, eq, lt}, {29'd0, r});
        check($sformatf("latency_%0d", t), cyc, d);
        check($sformatf("busy_at_done_%0d", t), {31'd0, busy}, 32'd0);
      end
    end
  end

  // Monitor for the 1-bit instance.
  always @(negedge clk) begin
    if (!rst && done1) begin
      if (q1_res.size() == 0) begin
        check("unexpected_done1", 32'd1, 32'd0);
      end else begin
        logic [2:0] r;
        int d, t;
        r = q1_res.pop_front();
        d = q1_due.pop_front();
        t = q1_tag.pop_front();
        $display("txn %0d (1-bit): gt=%0b eq=%0b lt=%0b at cycle %0d", t, gt1, eq1, lt1, cyc);
        check($sformatf("result_%0d", t), {29'd0, gt1, eq1, lt1}, {29'd0, r});
        check($sformatf("latency_%0d", t), cyc, d);
        check($sformatf("busy_at_done_%0d", t), {31'd0, busy1}, 32'd0);
      end
    end
  end

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic s,
                       input logic [2:0] r, input int k, input int tag, input bit push);
    a = x; b = y; signed_mode = s; start = 1'b1;
    if (push) begin
      q_res.push_back(r);
      q_due.push_back(cyc + 1 + k);
      q_tag.push_back(tag);
    end
    @(negedge clk);
    start = 1'b0;
    check($sformatf("busy_after_accept_%0d", tag), {31'd0, busy}, 32'd1);
    check($sformatf("flags_held_%0d", tag), {29'd0, gt, eq, lt}, {29'd0, last_exp});
    if (push) last_exp = r;
  endtask

  task automatic wait_done(input int tag);
    int i = 0;
    while (busy && i < 40) begin
      @(negedge clk);
      i++;
    end
    check($sformatf("completes_%0d", tag), {31'd0, busy}, 32'd0);
  endtask

  task automatic issue1(input logic x, input logic y, input logic [2:0] r, input int tag);
    int i = 0;
    a1 = x; b1 = y; s1 = 1'b0; start1 = 1'b1;
    q1_res.push_back(r);
    q1_due.push_back(cyc + 2);
    q1_tag.push_back(tag);
    @(negedge clk);
    start1 = 1'b0;
    check($sformatf("busy1_after_accept_%0d", tag), {31'd0, busy1}, 32'd1);
    while (busy1 && i < 10) begin
      @(negedge clk);
      i++;
    end
    check($sformatf("completes_%0d", tag), {31'd0, busy1}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", {27'd0, busy, done, gt, eq, lt}, 32'd0);
    check("reset_outputs1", {27'd0, busy1, done1, gt1, eq1, lt1}, 32'd0);
    rst = 1'b0;

    // Back-to-back sequence: each new start lands in the previous done cycle.
    issue(16'h1234, 16'h1234, 1'b0, R_EQ, 4, 1, 1'b1); wait_done(1);
    issue(16'h8000, 16'h7FFF, 1'b0, R_GT, 1, 2, 1'b1); wait_done(2);
    issue(16'h8000, 16'h7FFF, 1'b1, R_LT, 1, 3, 1'b1); wait_done(3);
    issue(16'h12A0, 16'h12B0, 1'b0, R_LT, 3, 4, 1'b1); wait_done(4);
    issue(16'hFFFF, 16'hFFFE, 1'b1, R_GT, 4, 5, 1'b1); wait_done(5);
    issue(16'h7000, 16'h9000, 1'b1, R_GT, 1, 6, 1'b1); wait_done(6);
    issue(16'h7000, 16'h9000, 1'b0, R_LT, 1, 7, 1'b1); wait_done(7);

    // Start pulsed mid-run with different operands must be ignored.
    issue(16'h1234, 16'h1234, 1'b0, R_EQ, 4, 8, 1'b1);
    a = 16'h0000; b = 16'hFFFF; signed_mode = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(8);

    // Reset while chunk 2 is being compared: immediate clear, no done pulse.
    issue(16'hABCD, 16'hABCD, 1'b0, R_EQ, 4, 9, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_outputs", {27'd0, busy, done, gt, eq, lt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_exp = 3'b000;
    issue(16'h00F0, 16'h00E0, 1'b0, R_GT, 3, 10, 1'b1); wait_done(10);

    // Single-bit configuration, all four operand pairs.
    issue1(1'b0, 1'b0, R_EQ, 11);
    issue1(1'b0, 1'b1, R_LT, 12);
    issue1(1'b1, 1'b0, R_GT, 13);
    issue1(1'b1, 1'b1, R_EQ, 14);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", q_res.size() + q1_res.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
